// File: rtl/aes_key_schedule_stream.sv
// AES-128/192/256 key expansion into an internal word buffer, then round keys are streamed
// over valid/ready in forward or reverse order. The ready flag rises Nw-nk cycles after start.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  logic [10:0] base;

  // Entry 0 sits in the most significant byte of the table.
  assign base = 11'd2047 - {a, 3'b000};
  assign y    = SBOX[base -: 8];
endmodule

module aes_key_schedule_stream #(
  parameter int MAX_NK = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [32*MAX_NK-1:0]  key,
  input  logic [3:0]            nk,
  output logic                  busy,
  output logic                  ready,
  output logic                  err,
  input  logic                  rk_rewind,
  input  logic                  rk_dec,
  output logic                  rk_valid,
  input  logic                  rk_ready,
  output logic [127:0]          rk_data,
  output logic [3:0]            rk_index,
  output logic                  rk_last
);
  localparam int DEPTH = 4 * (MAX_NK + 7);
  localparam int AW    = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_READY  = 2'd2;

  logic [1:0]            state;
  logic [31:0]           wbuf [DEPTH];
  logic [3:0]            nk_r;
  logic [3:0]            nr;
  logic [AW-1:0]         wi;
  logic [AW-1:0]         nw_m1;
  logic [3:0]            mcnt;
  logic [7:0]            rcon;
  logic [3:0]            ptr;
  logic                  dir;
  logic                  err_r;
  logic                  legal;
  logic                  load;
  logic [32*MAX_NK-1:0]  key_al;
  logic [31:0]           prev;
  logic [31:0]           sub_in;
  logic [31:0]           sub_out;
  logic [31:0]           temp;
  logic [31:0]           w_new;
  logic [AW-1:0]         rb;
  logic                  xfer;
  logic                  at_last;

  assign legal  = (nk == 4'd4 || nk == 4'd6 || nk == 4'd8) && (int'(nk) <= MAX_NK);
  assign load   = start && (state != S_EXPAND) && legal;
  assign key_al = key << (32 * (MAX_NK - int'(nk)));
  assign nr     = nk_r + 4'd6;
  assign nw_m1  = AW'({nk_r, 2'b00}) + AW'(27);

  assign prev   = wbuf[wi - AW'(1)];
  assign sub_in = (mcnt == 4'd0) ? {prev[23:0], prev[31:24]} : prev;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.a(sub_in[8*b +: 8]), .y(sub_out[8*b +: 8]));
  end

  always_comb begin
    temp = prev;
    if (mcnt == 4'd0)
      temp = sub_out ^ {rcon, 24'h0};
    else if (nk_r == 4'd8 && mcnt == 4'd4)
      temp = sub_out;
  end

  assign w_new = wbuf[wi - AW'(nk_r)] ^ temp;

  // Buffer carries no reset; every word is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int j = 0; j < MAX_NK; j++)
        wbuf[j] <= key_al[32*(MAX_NK-j)-1 -: 32];
    end else if (state == S_EXPAND) begin
      wbuf[wi] <= w_new;
    end
  end

  assign xfer    = (state == S_READY) && rk_ready;
  assign at_last = dir ? (ptr == 4'd0) : (ptr == nr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      err_r <= 1'b0;
      nk_r  <= 4'd4;
      wi    <= '0;
      mcnt  <= '0;
      rcon  <= 8'h01;
      ptr   <= '0;
      dir   <= 1'b0;
    end else if (state == S_EXPAND) begin
      wi   <= wi + AW'(1);
      mcnt <= (mcnt == nk_r - 4'd1) ? 4'd0 : mcnt + 4'd1;
      if (mcnt == 4'd0)
        rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      if (wi == nw_m1) begin
        state <= S_READY;
        ptr   <= '0;
        dir   <= 1'b0;
      end
    end else if (start) begin
      if (legal) begin
        state <= S_EXPAND;
        err_r <= 1'b0;
        nk_r  <= nk;
        wi    <= AW'(nk);
        mcnt  <= '0;
        rcon  <= 8'h01;
      end else begin
        state <= S_IDLE;
        err_r <= 1'b1;
      end
    end else if (state == S_READY) begin
      // A rewind wins over a transfer in the same cycle.
      if (rk_rewind) begin
        ptr <= rk_dec ? nr : 4'd0;
        dir <= rk_dec;
      end else if (xfer) begin
        if (at_last)
          ptr <= dir ? nr : 4'd0;
        else
          ptr <= dir ? ptr - 4'd1 : ptr + 4'd1;
      end
    end
  end

  assign rb       = AW'({ptr, 2'b00});
  assign busy     = (state == S_EXPAND);
  assign ready    = (state == S_READY);
  assign err      = err_r;
  assign rk_valid = ready;
  assign rk_index = ready ? ptr : 4'd0;
  assign rk_last  = ready && at_last;
  assign rk_data  = ready ? {wbuf[rb], wbuf[rb + AW'(1)], wbuf[rb + AW'(2)], wbuf[rb + AW'(3)]}
                          : 128'h0;
endmodule

// File: tb/tb_aes_key_schedule_stream.sv
// Directed bench: known-answer key schedules with a scoreboard monitor on the round-key port.

module tb_aes_key_schedule_stream;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [255:0] key = '0;
  logic [3:0]   nk = 4'd4;
  logic         busy, ready, err;
  logic         rk_rewind = 1'b0;
  logic         rk_dec = 1'b0;
  logic         rk_valid;
  logic         rk_ready = 1'b0;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;
  logic         rk_last;

  typedef struct {
    logic [3:0]   idx;
    logic         last;
    logic [127:0] data;
  } exp_t;

  exp_t         sbq[$];
  int           n_chk = 0;
  int           n_pass = 0;
  logic [127:0] rk4 [11];

  localparam logic [255:0] K128 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] K192 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_schedule_stream #(.MAX_NK(8)) dut (
    .clk(clk), .reset(reset), .start(start), .key(key), .nk(nk),
    .busy(busy), .ready(ready), .err(err),
    .rk_rewind(rk_rewind), .rk_dec(rk_dec), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_data(rk_data), .rk_index(rk_index), .rk_last(rk_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every accepted round key is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && rk_valid && rk_ready && !rk_rewind) begin
      if (sbq.size() == 0) begin
        n_chk++;
        $display("FAIL rk_unexpected: got idx %0d data %h expected nothing", rk_index, rk_data);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        n_chk++;
        if (rk_index === e.idx && rk_last === e.last && rk_data === e.data) n_pass++;
        else $display("FAIL rk_stream: got idx %0d last %b data %h expected idx %0d last %b data %h",
                      rk_index, rk_last, rk_data, e.idx, e.last, e.data);
      end
    end
  end

  task automatic push(input logic [3:0] idx, input logic last, input logic [127:0] data);
    exp_t e;
    e.idx = idx; e.last = last; e.data = data;
    sbq.push_back(e);
  endtask

  task automatic start_key(input logic [255:0] k, input logic [3:0] n, input logic [2:0] exp_st);
    start = 1'b1; key = k; nk = n;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_status", {busy, ready, err}, exp_st);
  endtask

  task automatic wait_ready(input int exp_cyc);
    int cyc = 0;
    while (!ready && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("ready_latency", cyc, exp_cyc);
  endtask

  task automatic rewind(input logic d);
    rk_rewind = 1'b1; rk_dec = d; rk_ready = 1'b0;
    @(posedge clk); #1;
    rk_rewind = 1'b0;
  endtask

  // Drains the scoreboard; returns the number of cycles it took.
  task automatic drain(input logic toggle, output int cyc);
    cyc = 0;
    while (sbq.size() > 0 && cyc < 100) begin
      rk_ready = toggle ? cyc[0] : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    rk_ready = 1'b0;
    if (sbq.size() > 0) begin
      chk("drain_timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  initial begin
    int cyc;
    rk4[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk4[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk4[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk4[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk4[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk4[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk4[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk4[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk4[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk4[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk4[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_status", {busy, ready, err, rk_valid, rk_last, rk_index}, 0);
    chk("reset_data", rk_data, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // AES-128 forward stream at full rate, including wrap back to round 0
    start_key(K128, 4'd4, 3'b100);
    wait_ready(40);
    for (int r = 0; r <= 10; r++) push(4'(r), r == 10, rk4[r]);
    push(4'd0, 1'b0, rk4[0]);
    drain(1'b0, cyc);
    chk("fwd_throughput", cyc, 12);

    // Reverse stream with stalls, last at round 0, then wrap to 10
    rewind(1'b1);
    for (int r = 10; r >= 0; r--) push(4'(r), r == 0, rk4[r]);
    push(4'd10, 1'b0, rk4[10]);
    drain(1'b1, cyc);

    // AES-192, restarted from READY
    start_key(K192, 4'd6, 3'b100);
    wait_ready(46);
    push(4'd0, 1'b0, 128'h8e73b0f7da0e6452c810f32b809079e5);
    drain(1'b0, cyc);
    rewind(1'b1);
    push(4'd12, 1'b0, 128'he98ba06f448c773c8ecc720401002202);
    drain(1'b0, cyc);

    // AES-256
    start_key(K256, 4'd8, 3'b100);
    wait_ready(52);
    rewind(1'b1);
    push(4'd14, 1'b0, 128'hfe4890d1e6188d0b046df344706c631e);
    drain(1'b0, cyc);

    // Illegal nk, recovery, and a start ignored during expansion
    start_key(K128, 4'd5, 3'b001);
    start_key(K128, 4'd4, 3'b100);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; key = K192; nk = 4'd6;
    @(posedge clk); #1;
    start = 1'b0;
    wait_ready(34);
    push(4'd0, 1'b0, rk4[0]);
    push(4'd1, 1'b0, rk4[1]);
    drain(1'b0, cyc);

    // Reset in the middle of an AES-256 expansion
    start_key(K256, 4'd8, 3'b100);
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrun_reset_status", {busy, ready, err, rk_valid, rk_last, rk_index}, 0);
    chk("midrun_reset_data", rk_data, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    start_key(K256, 4'd8, 3'b100);
    wait_ready(52);
    rewind(1'b1);
    push(4'd14, 1'b0, 128'hfe4890d1e6188d0b046df344706c631e);
    drain(1'b0, cyc);

    chk("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
